// File: rtl/dac_spi_pkg.sv
// Shared types and parameter limits for the DAC SPI sequencer.
// Optional LDAC strobe is enabled by DAC_SPI_SEQ_LDAC_EN.
package dac_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP,
        LATCH,
        DONE
    } state_e;

    localparam int DATA_W_MIN = 8;
    localparam int DATA_W_MAX = 32;
    localparam int CH_NUM_MIN = 1;
    localparam int CH_NUM_MAX = 8;
    localparam int DIV_MIN    = 1;
    localparam int DIV_MAX    = 255;
    localparam int GAP_MIN    = 1;
    localparam int GAP_MAX    = 255;
    localparam int DIV_W      = 8;
    localparam int WAIT_W     = 9;

endpackage

// File: rtl/dac_sclk_div.sv
// SCLK half-period tick generator; counter restarts whenever disabled.
// Used by dac_spi_seq (see DAC_SPI_SEQ_LDAC_EN there).
module dac_sclk_div
    import dac_spi_pkg::*;
#(
    parameter int DIV_PARAM = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == DIV_W'(DIV_PARAM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/dac_spi_seq.sv
// Multi-channel SPI DAC update sequencer, one frame per masked channel.
// Define DAC_SPI_SEQ_LDAC_EN to add the DAC_LDAC_N simultaneous-update strobe.
module dac_spi_seq
    import dac_spi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int CH_NUM    = 2,
    parameter int DIV_PARAM = 2,
    parameter int CS_GAP    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CH_NUM*DATA_W-1:0] DAC_DATA,
    input  logic [CH_NUM-1:0]        Ch_Mask,
    input  logic                     Start,
    output logic                     Busy,
    output logic                     Set_Done,
    output logic                     DAC_CS_N,
    output logic                     DAC_SCLK,
    output logic                     DAC_DIN,
    output logic                     DAC_State
`ifdef DAC_SPI_SEQ_LDAC_EN
    ,
    output logic                     DAC_LDAC_N
`endif
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
        CH_NUM < CH_NUM_MIN || CH_NUM > CH_NUM_MAX ||
        DIV_PARAM < DIV_MIN || DIV_PARAM > DIV_MAX ||
        CS_GAP < GAP_MIN || CS_GAP > GAP_MAX) begin : g_bad_param
        $error("dac_spi_seq: parameter out of range");
    end

    state_e                     state, state_nxt;
    logic [CH_NUM*DATA_W-1:0]   data_q;
    logic [CH_NUM-1:0]          mask_q, low_bit;
    logic [DATA_W-1:0]          shifter, load_word;
    logic [BIT_W-1:0]           bit_cnt;
    logic [WAIT_W-1:0]          wait_cnt;
    logic                       tick, last_fall, cs_low_nxt;
    logic                       cs_n, sclk, din;

    dac_sclk_div #(
        .DIV_PARAM(DIV_PARAM)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state == SHIFT),
        .tick (tick)
    );

    assign last_fall = tick && sclk &&
                       (bit_cnt == BIT_W'(DATA_W - 1));

    // Lowest pending channel wins.
    always_comb begin
        load_word = '0;
        low_bit   = '0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (mask_q[k]) begin
                load_word  = data_q[k*DATA_W +: DATA_W];
                low_bit    = '0;
                low_bit[k] = 1'b1;
            end
        end
    end

    // CS_N is registered from the next state so it is already low in LOAD.
    always_comb begin
        state_nxt  = state;
        cs_low_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt  = LOAD;
                    cs_low_nxt = |Ch_Mask;
                end
            end
            LOAD: begin
                if (|mask_q) begin
                    state_nxt  = SHIFT;
                    cs_low_nxt = 1'b1;
                end else begin
                    state_nxt = LATCH;
                end
            end
            SHIFT: begin
                if (last_fall) begin
                    state_nxt = GAP;
                end else begin
                    cs_low_nxt = 1'b1;
                end
            end
            GAP: begin
                if (wait_cnt == WAIT_W'(CS_GAP - 1)) begin
                    state_nxt  = LOAD;
                    cs_low_nxt = |mask_q;
                end
            end
            LATCH: begin
`ifdef DAC_SPI_SEQ_LDAC_EN
                if (wait_cnt == WAIT_W'(2 * DIV_PARAM - 1)) begin
                    state_nxt = DONE;
                end
`else
                state_nxt = DONE;
`endif
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            din      <= 1'b1;
            data_q   <= '0;
            mask_q   <= '0;
            shifter  <= '0;
            bit_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            cs_n  <= ~cs_low_nxt;
            if (state_nxt != state) begin
                wait_cnt <= '0;
            end else if (state == GAP || state == LATCH) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (state == IDLE && Start) begin
                data_q <= DAC_DATA;
                mask_q <= Ch_Mask;
            end
            if (state == LOAD && |mask_q) begin
                shifter <= load_word;
                mask_q  <= mask_q & ~low_bit;
                bit_cnt <= '0;
            end
            if (tick) begin
                sclk <= ~sclk;
                if (!sclk) begin
                    din     <= shifter[DATA_W-1];
                    shifter <= {shifter[DATA_W-2:0], 1'b0};
                end else begin
                    bit_cnt <= bit_cnt + BIT_W'(1);
                end
            end
        end
    end

`ifdef DAC_SPI_SEQ_LDAC_EN
    logic ldac_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldac_n <= 1'b1;
        end else begin
            ldac_n <= (state_nxt != LATCH);
        end
    end

    assign DAC_LDAC_N = ldac_n;
`endif

    assign Busy      = (state != IDLE);
    assign Set_Done  = (state == DONE);
    assign DAC_CS_N  = cs_n;
    assign DAC_SCLK  = sclk;
    assign DAC_DIN   = din;
    assign DAC_State = cs_n;

endmodule
